// File: rtl/pagetable_arbiter.sv
// rtl/pagetable_arbiter.sv - page-table RAM arbiter for MMU lookups, CPU writes and table clear
// One request is granted per IDLE visit; every access completes with a registered ack pulse.
module pagetable_arbiter #(
  parameter int PT_DEPTH   = 8192,
  parameter int PT_AW      = 13,
  parameter int PT_DW      = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             arst,
  input  logic [7:0]       cpu_status,
  input  logic             lk_req,
  input  logic [PT_AW-1:0] lk_addr,
  output logic             lk_ack,
  output logic [PT_DW-1:0] lk_data,
  input  logic             wr_req,
  input  logic [PT_AW-1:0] wr_addr,
  input  logic [PT_DW-1:0] wr_data,
  output logic             wr_ack,
  output logic             wr_err,
  input  logic             clr_start,
  output logic             clr_busy,
  output logic             clr_done,
  output logic             ram_en,
  output logic             ram_we,
  output logic [PT_AW-1:0] ram_addr,
  output logic [PT_DW-1:0] ram_wdata,
  input  logic [PT_DW-1:0] ram_rdata
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0]    STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [PT_AW-1:0] LAST_ADDR  = PT_AW'(PT_DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_CLEAR} state_e;

  state_e             state_q, state_d;
  logic [SW-1:0]      starve_q, starve_d;
  logic [PT_AW-1:0]   clr_addr_q, clr_addr_d;
  logic [PT_AW-1:0]   lk_addr_q, lk_addr_d;
  logic               bypass_q, bypass_d;
  logic               err_q, err_d;
  logic               lk_ack_q, lk_ack_d;
  logic               wr_ack_q, wr_ack_d;
  logic               wr_err_q, wr_err_d;
  logic               clr_busy_q, clr_busy_d;
  logic               clr_done_q, clr_done_d;
  logic               ram_en_q, ram_en_d;
  logic               ram_we_q, ram_we_d;
  logic [PT_AW-1:0]   ram_addr_q, ram_addr_d;
  logic [PT_DW-1:0]   ram_wdata_q, ram_wdata_d;

  logic mode, paging_en, halt;
  logic gnt_clr, gnt_wr, gnt_lk;
  logic unused_status;

  assign mode          = cpu_status[2];
  assign paging_en     = cpu_status[3];
  assign halt          = cpu_status[4];
  assign unused_status = ^{cpu_status[7:5], cpu_status[1:0]};

  // A starved writer outranks lookups; halt freezes everything except clear.
  always_comb begin
    gnt_clr = 1'b0;
    gnt_wr  = 1'b0;
    gnt_lk  = 1'b0;
    if (state_q == S_IDLE) begin
      if (clr_start)                                    gnt_clr = 1'b1;
      else if (!halt && wr_req && starve_q == STARVE_LIM) gnt_wr = 1'b1;
      else if (!halt && lk_req)                         gnt_lk = 1'b1;
      else if (!halt && wr_req)                         gnt_wr = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    clr_addr_d  = clr_addr_q;
    lk_addr_d   = lk_addr_q;
    bypass_d    = bypass_q;
    err_d       = err_q;
    lk_ack_d    = 1'b0;
    wr_ack_d    = 1'b0;
    wr_err_d    = 1'b0;
    clr_busy_d  = clr_busy_q;
    clr_done_d  = 1'b0;
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;

    case (state_q)
      S_IDLE: begin
        if (!wr_req) starve_d = '0;
        if (gnt_clr) begin
          state_d     = S_CLEAR;
          clr_busy_d  = 1'b1;
          clr_addr_d  = '0;
          ram_en_d    = 1'b1;
          ram_we_d    = 1'b1;
          ram_addr_d  = '0;
          ram_wdata_d = '0;
        end else if (gnt_lk) begin
          state_d   = S_READ;
          lk_addr_d = lk_addr;
          bypass_d  = !paging_en;
          if (wr_req && starve_q != STARVE_LIM) starve_d = starve_q + SW'(1);
          if (paging_en) begin
            ram_en_d   = 1'b1;
            ram_addr_d = lk_addr;
          end
        end else if (gnt_wr) begin
          state_d  = S_WRITE;
          starve_d = '0;
          err_d    = mode;
          if (!mode) begin
            ram_en_d    = 1'b1;
            ram_we_d    = 1'b1;
            ram_addr_d  = wr_addr;
            ram_wdata_d = wr_data;
          end
        end
      end
      S_READ: begin
        state_d  = S_IDLE;
        lk_ack_d = 1'b1;
      end
      S_WRITE: begin
        state_d  = S_IDLE;
        wr_ack_d = 1'b1;
        wr_err_d = err_q;
      end
      S_CLEAR: begin
        if (clr_addr_q == LAST_ADDR) begin
          state_d    = S_IDLE;
          clr_busy_d = 1'b0;
          clr_done_d = 1'b1;
        end else begin
          clr_addr_d = clr_addr_q + PT_AW'(1);
          ram_en_d   = 1'b1;
          ram_we_d   = 1'b1;
          ram_addr_d = clr_addr_q + PT_AW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q     <= S_IDLE;
      starve_q    <= '0;
      clr_addr_q  <= '0;
      lk_addr_q   <= '0;
      bypass_q    <= 1'b0;
      err_q       <= 1'b0;
      lk_ack_q    <= 1'b0;
      wr_ack_q    <= 1'b0;
      wr_err_q    <= 1'b0;
      clr_busy_q  <= 1'b0;
      clr_done_q  <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      clr_addr_q  <= clr_addr_d;
      lk_addr_q   <= lk_addr_d;
      bypass_q    <= bypass_d;
      err_q       <= err_d;
      lk_ack_q    <= lk_ack_d;
      wr_ack_q    <= wr_ack_d;
      wr_err_q    <= wr_err_d;
      clr_busy_q  <= clr_busy_d;
      clr_done_q  <= clr_done_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  // RAM read data arrives in the ack cycle, so the result is muxed combinationally.
  assign lk_data   = lk_ack_q ? (bypass_q ? PT_DW'(lk_addr_q) : ram_rdata) : '0;
  assign lk_ack    = lk_ack_q;
  assign wr_ack    = wr_ack_q;
  assign wr_err    = wr_err_q;
  assign clr_busy  = clr_busy_q;
  assign clr_done  = clr_done_q;
  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;

endmodule
